detect_counter: RTL
===================

DETECT_COUNTER -- requirements
Module: detect_counter

Interface
REQ-001 Parameter: REFRESH_W, 18, width of the display refresh counter; its MSB selects the active digit.
REQ-002 Parameter: STRETCH_LEN, 10_000_000, number of cycles the hit LED stays lit after a counted event.
REQ-003 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: detected  input  1  level from the upstream 1100 Moore detector; high while the detector sits in its detect state.
REQ-006 Port: clr  input  1  synchronous clear of the event count only.
REQ-007 Port: count_bcd  output  8  [7:4] tens digit, [3:0] units digit, registered.
REQ-008 Port: seg  output  7  active-low segments {g,f,e,d,c,b,a}, registered.
REQ-009 Port: an  output  4  active-low digit enables; an[3:2] always 1.
REQ-010 Port: hit  output  1  stretched event indicator, registered.

Function
REQ-011 Edge detect: register detected as det_q; event = detected & ~det_q; a level held N cycles counts exactly once.
REQ-012 Counter: on event, the units digit increments; units 9 -> 0 carries into tens; 99 -> 00 wraps with no flag.
REQ-013 Latency: count_bcd reflects an event on the cycle after the detected rising edge, i.e. 1 cycle after det rises.
REQ-014 clr: count_bcd = 8'h00 on the next cycle; clr and event in the same cycle -> clr wins and the event is dropped; det_q still updates.
REQ-015 Refresh: a free-running REFRESH_W-bit counter; MSB=0 drives units (an=4'b1110), MSB=1 drives tens (an=4'b1101).
REQ-016 seg/an are registered and update one cycle after the refresh MSB or count changes.
REQ-017 Segment map, active-low: 0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 3=7'b0110000, 4=7'b0011001, 5=7'b0010010, 6=7'b0000010, 7=7'b1111000, 8=7'b0000000, 9=7'b0010000; any other code = 7'b1111111.
REQ-018 Stretcher FSM, IDLE: hit=0; on event go to HOLD and load the down-counter with STRETCH_LEN-1.
REQ-019 Stretcher FSM, HOLD: hit=1; decrement each cycle; at 0 return to IDLE.
REQ-020 Stretcher FSM, retrigger: an event in HOLD reloads STRETCH_LEN-1 and stays in HOLD.
REQ-021 Stretcher FSM: clr does not affect it; an illegal state returns to IDLE.
REQ-022 The stretch down-counter width is $clog2(STRETCH_LEN); STRETCH_LEN >= 2.

Reset
REQ-023 rst is sampled only on a rising clk edge and has priority over clr and event.
REQ-024 Reset values: count_bcd=8'h00, det_q=0, refresh=0, FSM=IDLE, hit=0, seg=7'b1000000, an=4'b1110.
REQ-025 If detected is high while rst deasserts, det_q=0 makes it count as an event on the first cycle out of reset; this is intended.
REQ-026 Reset mid-HOLD clears hit on the next edge with no residual stretch.

Structure
REQ-027 The shared package holds the segment pattern constants (SEG_0..SEG_9, SEG_BLANK) and the FSM state encodings (ST_IDLE=1'b0, ST_HOLD=1'b1).
REQ-028 One sub-module, bcd_to_seg (4-bit in, 7-bit out, combinational, REQ-017 map), instantiated once after the digit mux.
REQ-029 Top level: edge detect, BCD counter, refresh counter, stretcher FSM, output registers; no other clocks or enables.

Verification (bench uses REFRESH_W=4, STRETCH_LEN=5)
REQ-030 Reset and single event: rst 2 cycles, then detected high 1 cycle -> count_bcd=8'h01 next cycle; hit high exactly 5 cycles.
REQ-031 Held level: detected high 7 cycles -> count_bcd advances by exactly 1.
REQ-032 Carry and wrap: 9 pulses -> 8'h09; 1 more -> 8'h10; 99 total -> 8'h99; 100th -> 8'h00.
REQ-033 Same-cycle clr/event: clr asserted on the event cycle with count 8'h37 -> 8'h00 next cycle, not 8'h01.
REQ-034 Retrigger: second event 3 cycles after the first -> hit stays high continuously for 3+5=8 cycles.
REQ-035 Display mux: count 8'h42, refresh MSB=0 -> an=4'b1110, seg=7'b0100100; MSB=1 -> an=4'b1101, seg=7'b0011001; an[3:2] never 0.

Source files
------------

// File: rtl/detect_counter_pkg.sv
// Shared constants for the detect counter: active-low segment patterns and
// stretcher FSM state encodings.
package detect_counter_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digit enables, active-low; upper two digits are never driven
  localparam logic [3:0] AN_UNITS = 4'b1110;
  localparam logic [3:0] AN_TENS  = 4'b1101;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } stretch_state_e;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low seven-segment decoder.
module bcd_to_seg
  import detect_counter_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Non-decimal codes blank the digit
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/detect_counter.sv
// Counts rising edges of the upstream sequence detector as a two-digit BCD
// value, multiplexes it onto a two-digit seven-segment display and stretches
// each counted event into a visible hit pulse.
module detect_counter
  import detect_counter_pkg::*;
#(
  parameter int unsigned REFRESH_W   = 18,
  parameter int unsigned STRETCH_LEN = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       detected,
  input  logic       clr,
  output logic [7:0] count_bcd,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       hit
);

  localparam int unsigned StretchW = $clog2(STRETCH_LEN);
  localparam logic [StretchW-1:0] StretchLoad = StretchW'(STRETCH_LEN - 1);

  logic                 det_q;
  logic                 evt;
  logic [3:0]           units_q, tens_q;
  logic [REFRESH_W-1:0] refresh_q;
  logic [3:0]           digit;
  logic [6:0]           seg_d, seg_q;
  logic [3:0]           an_d, an_q;
  stretch_state_e       state_q, state_d;
  logic [StretchW-1:0]  scnt_q, scnt_d;
  logic                 hit_d, hit_q;

  // Edge detect: a held level counts once
  always_ff @(posedge clk) begin
    if (rst) det_q <= 1'b0;
    else     det_q <= detected;
  end

  assign evt = detected & ~det_q;

  // BCD event counter; clr beats a coincident event, 99 wraps silently to 00
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      units_q <= 4'd0;
      tens_q  <= 4'd0;
    end else if (evt) begin
      if (units_q == 4'd9) begin
        units_q <= 4'd0;
        tens_q  <= (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
      end else begin
        units_q <= units_q + 4'd1;
      end
    end
  end

  assign count_bcd = {tens_q, units_q};

  // Free-running refresh counter; its MSB picks the displayed digit
  always_ff @(posedge clk) begin
    if (rst) refresh_q <= '0;
    else     refresh_q <= refresh_q + REFRESH_W'(1);
  end

  // Digit mux ahead of the single shared decoder
  always_comb begin
    digit = units_q;
    an_d  = AN_UNITS;
    if (refresh_q[REFRESH_W-1]) begin
      digit = tens_q;
      an_d  = AN_TENS;
    end
  end

  bcd_to_seg u_bcd_to_seg (
    .bcd (digit),
    .seg (seg_d)
  );

  // Display output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= SEG_0;
      an_q  <= AN_UNITS;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

  // Stretcher state register; clr deliberately has no effect here
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
    end
  end

  // Stretcher next state: load on event, count down in HOLD, retrigger reloads
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    case (state_q)
      ST_IDLE: begin
        if (evt) begin
          state_d = ST_HOLD;
          scnt_d  = StretchLoad;
        end
      end
      ST_HOLD: begin
        if (evt) begin
          scnt_d = StretchLoad;
        end else if (scnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          scnt_d = scnt_q - StretchW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        scnt_d  = '0;
      end
    endcase
  end

  // Stretcher output: hit is registered from the next state so it lines up with HOLD
  always_comb begin
    hit_d = (state_d == ST_HOLD);
  end

  // Hit output register
  always_ff @(posedge clk) begin
    if (rst) hit_q <= 1'b0;
    else     hit_q <= hit_d;
  end

  assign hit = hit_q;

endmodule
